fetch_prefetch_unit: RTL and testbench
======================================

// Module: fetch_prefetch_unit
// PURPOSE
//  Parametrised instruction-fetch front end for the pipelined RISC-V core; replaces the single-cycle PC/PC+4/branch-mux path.
//  Owns the PC, issues pipelined requests to a variable-latency instruction memory and buffers up to DEPTH in-order {pc,instr} entries.
//  Drives a valid/ready stream into decode and accepts redirects (branch/jump/trap) from execute, discarding stale responses.
// PARAMETERS
//  XLEN      64          address/PC width
//  DEPTH     4           slot-buffer entries = max requests outstanding + buffered (power of 2, >=2)
//  RESET_PC  64'h0       PC fetched first after reset
// PORTS
//  clk             in   1     clock, all state on rising edge
//  reset           in   1     asynchronous, active-high
//  imem_req_valid  out  1     fetch request
//  imem_req_ready  in   1     memory accepts request
//  imem_addr       out  XLEN  request address, bits[1:0]=0
//  imem_rsp_valid  in   1     response, strictly in request order, >=1 cycle after acceptance
//  imem_rsp_data   in   32    instruction word
//  redirect_valid  in   1     flush and restart fetch
//  redirect_pc     in   XLEN  new PC; bits[1:0] ignored (forced 0)
//  if_valid        out  1     head entry holds a returned instruction
//  if_ready        in   1     decode accepts head
//  if_pc           out  XLEN  PC of head
//  if_instr        out  32    instruction of head
//  perf_fetched    out  32    instructions delivered to decode (FETCH_PERF_EN)
//  perf_flushed    out  32    entries/responses discarded by redirect (FETCH_PERF_EN)
// BEHAVIOUR
//  Reset: imem_req_valid=0, imem_addr=RESET_PC, if_valid=0, if_pc=0, if_instr=0, perf_*=0; all pointers/counters 0, fetch_pc=RESET_PC.
//  Slot buffer: alloc/fill/read pointers (log2 DEPTH+1 bits, wrap mod DEPTH). Request handshake allocates slot, writes pc.
//  imem_req_valid = (allocated < DEPTH) && !redirect_valid; first request the cycle after reset deasserts.
//  Handshake (req_valid&&req_ready): fetch_pc <= fetch_pc+4, wraps mod 2^XLEN; imem_addr = fetch_pc (registered).
//  Response: if discard_cnt>0, decrement and drop; else write instr into fill slot, advance fill pointer.
//  if_valid = fill != read; outputs combinational from head slot. if_valid&&if_ready advances read, frees slot.
//  Latency: response arriving cycle N visible on if_* at cycle N+1 (registered slot); best-case throughput 1 instr/cycle.
//  Full: DEPTH slots allocated -> no request; slot freed by dequeue re-enables request same cycle (ready->valid path allowed).
//  Redirect (priority over everything this cycle): all pointers reset to equal, fetch_pc <= {redirect_pc[XLEN-1:2],2'b00},
//   discard_cnt <= discard_cnt + inflight + (req handshake this cycle) - (rsp_valid this cycle); same-cycle dequeue ignored.
//   inflight = alloc - fill pointers (requests accepted, response not yet consumed). Request from new PC in following cycle.
//  Back-to-back redirects accumulate discard_cnt; discard_cnt width log2(2*DEPTH)+1, never overflows (<=DEPTH outstanding).
//  Response with no outstanding request: protocol error; simulation assertion fires, RTL ignores it.
//  Reset mid-operation: asynchronous return to reset state; in-flight responses after reset are memory's responsibility to cancel.
// CONFIGURATION
//  FETCH_PERF_EN defined: perf_fetched += 1 per dequeue, perf_flushed += valid-buffered entries dropped + discarded responses; both saturate at 2^32-1.
//  FETCH_PERF_EN undefined: counters not built, perf_fetched=perf_flushed=0 constantly; ports remain.
// STRUCTURE
//  Package riscv_fetch_pkg: XLEN default, INSTR_W=32, NOP=32'h00000013, opcode constants, fetch_entry_t {pc, instr}.
//  Sub-module fetch_slot_buffer: DEPTH-entry storage with alloc/fill/read pointers and flush; top holds PC, request logic, discard_cnt, perf.
// TESTING
//  Reset release, req_ready=1, 1-cycle memory -> addresses 0,4,8,...; if_pc/if_instr match, 1 instr/cycle after 2-cycle warm-up.
//  if_ready=0, DEPTH=4 -> exactly 4 requests accepted, imem_req_valid drops; one dequeue -> one new request at 0x10.
//  3 responses outstanding, redirect_pc=0x103 -> next addr 0x100; 3 stale responses dropped; first if_pc=0x100.
//  Redirect same cycle as rsp_valid and req handshake -> discard_cnt counts req, not rsp; no stale instr reaches if_*.
//  fetch_pc=2^64-4 -> next request addr 0; random req_ready/rsp latency/if_ready/redirects vs scoreboard, FETCH_PERF_EN on and off.

Source files
------------

// File: rtl/riscv_fetch_pkg.sv
// Shared fetch-side types and constants for the RISC-V front end.
// Consumers: fetch_slot_buffer, fetch_prefetch_unit.
package riscv_fetch_pkg;

    localparam int XLEN_DEFAULT = 64;
    localparam int INSTR_W      = 32;

    localparam logic [INSTR_W-1:0] NOP = 32'h0000_0013;

    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    typedef struct packed {
        logic [XLEN_DEFAULT-1:0] pc;
        logic [INSTR_W-1:0]      instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_slot_buffer.sv
// In-order slot buffer: a slot is allocated (pc written) at request time,
// filled with its instruction on response, and freed on dequeue.
module fetch_slot_buffer
    import riscv_fetch_pkg::*;
#(
    parameter int XLEN  = XLEN_DEFAULT,
    parameter int DEPTH = 4,
    parameter int PTR_W = $clog2(DEPTH) + 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush,
    input  logic               alloc_en,
    input  logic [XLEN-1:0]    alloc_pc,
    input  logic               fill_en,
    input  logic [INSTR_W-1:0] fill_instr,
    input  logic               deq_en,
    output logic               head_valid,
    output logic [XLEN-1:0]    head_pc,
    output logic [INSTR_W-1:0] head_instr,
    output logic [PTR_W-1:0]   alloc_cnt,
    output logic [PTR_W-1:0]   inflight,
    output logic [PTR_W-1:0]   buffered
);

    localparam int IDX_W = $clog2(DEPTH);

    logic [PTR_W-1:0]   alloc_ptr;
    logic [PTR_W-1:0]   fill_ptr;
    logic [PTR_W-1:0]   read_ptr;
    logic [XLEN-1:0]    pc_mem    [DEPTH];
    logic [INSTR_W-1:0] instr_mem [DEPTH];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            alloc_ptr <= '0;
            fill_ptr  <= '0;
            read_ptr  <= '0;
        end else if (flush) begin
            alloc_ptr <= '0;
            fill_ptr  <= '0;
            read_ptr  <= '0;
        end else begin
            if (alloc_en) alloc_ptr <= alloc_ptr + 1'b1;
            if (fill_en)  fill_ptr  <= fill_ptr + 1'b1;
            if (deq_en)   read_ptr  <= read_ptr + 1'b1;
        end
    end

    // Slot contents carry no reset; validity is tracked purely by the pointers.
    always_ff @(posedge clk) begin
        if (alloc_en && !flush) pc_mem[alloc_ptr[IDX_W-1:0]]   <= alloc_pc;
        if (fill_en && !flush)  instr_mem[fill_ptr[IDX_W-1:0]] <= fill_instr;
    end

    assign head_valid = (fill_ptr != read_ptr);
    assign head_pc    = pc_mem[read_ptr[IDX_W-1:0]];
    assign head_instr = instr_mem[read_ptr[IDX_W-1:0]];
    assign alloc_cnt  = alloc_ptr - read_ptr;
    assign inflight   = alloc_ptr - fill_ptr;
    assign buffered   = fill_ptr - read_ptr;

endmodule

// File: rtl/fetch_prefetch_unit.sv
// Instruction fetch front end: PC, pipelined imem requests, stale-response discard.
// Optional perf counters are built when FETCH_PERF_EN is defined.
module fetch_prefetch_unit
    import riscv_fetch_pkg::*;
#(
    parameter int              XLEN     = XLEN_DEFAULT,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               reset,
    output logic               imem_req_valid,
    input  logic               imem_req_ready,
    output logic [XLEN-1:0]    imem_addr,
    input  logic               imem_rsp_valid,
    input  logic [INSTR_W-1:0] imem_rsp_data,
    input  logic               redirect_valid,
    input  logic [XLEN-1:0]    redirect_pc,
    output logic               if_valid,
    input  logic               if_ready,
    output logic [XLEN-1:0]    if_pc,
    output logic [INSTR_W-1:0] if_instr,
    output logic [31:0]        perf_fetched,
    output logic [31:0]        perf_flushed
);

    localparam int PTR_W  = $clog2(DEPTH) + 1;
    localparam int DISC_W = $clog2(2 * DEPTH) + 1;

    logic               running;
    logic [XLEN-1:0]    fetch_pc;
    logic [DISC_W-1:0]  discard_cnt;
    logic               head_valid;
    logic [XLEN-1:0]    head_pc;
    logic [INSTR_W-1:0] head_instr;
    logic [PTR_W-1:0]   alloc_cnt;
    logic [PTR_W-1:0]   inflight;
    logic [PTR_W-1:0]   buffered;
    logic               deq;
    logic               deq_en;
    logic               req_hs;
    logic               rsp_drop;
    logic               rsp_fill;
    logic               rsp_legal;
    logic [DISC_W-1:0]  occupied;

    assign deq      = head_valid && if_ready;
    assign deq_en   = deq && !redirect_valid;
    assign req_hs   = imem_req_valid && imem_req_ready;
    assign rsp_drop = imem_rsp_valid && (discard_cnt != '0);
    assign rsp_fill = imem_rsp_valid && (discard_cnt == '0) && (inflight != '0);
    assign rsp_legal = rsp_drop || rsp_fill;

    // Stale requests still owed by memory hold capacity too, which bounds discard_cnt by DEPTH.
    assign occupied = DISC_W'(alloc_cnt) + discard_cnt;
    assign imem_req_valid = running && !redirect_valid &&
                            ((occupied < DISC_W'(DEPTH)) || deq);
    assign imem_addr = fetch_pc;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            running     <= 1'b0;
            fetch_pc    <= RESET_PC;
            discard_cnt <= '0;
        end else begin
            running <= 1'b1;
            if (redirect_valid) begin
                fetch_pc    <= {redirect_pc[XLEN-1:2], 2'b00};
                discard_cnt <= discard_cnt + DISC_W'(inflight) + DISC_W'(req_hs)
                               - DISC_W'(rsp_legal);
            end else begin
                if (req_hs)   fetch_pc    <= fetch_pc + XLEN'(4);
                if (rsp_drop) discard_cnt <= discard_cnt - 1'b1;
            end
        end
    end

    fetch_slot_buffer #(
        .XLEN  (XLEN),
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_slots (
        .clk        (clk),
        .reset      (reset),
        .flush      (redirect_valid),
        .alloc_en   (req_hs),
        .alloc_pc   (fetch_pc),
        .fill_en    (rsp_fill && !redirect_valid),
        .fill_instr (imem_rsp_data),
        .deq_en     (deq_en),
        .head_valid (head_valid),
        .head_pc    (head_pc),
        .head_instr (head_instr),
        .alloc_cnt  (alloc_cnt),
        .inflight   (inflight),
        .buffered   (buffered)
    );

    assign if_valid = head_valid;
    assign if_pc    = head_valid ? head_pc : '0;
    assign if_instr = head_valid ? head_instr : '0;

    assert property (@(posedge clk) disable iff (reset) imem_rsp_valid |-> rsp_legal);

`ifdef FETCH_PERF_EN
    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
    endfunction

    logic [31:0] fetched_q;
    logic [31:0] flushed_q;
    logic [31:0] flush_inc;

    // On redirect every filled slot is lost plus any response consumed this cycle.
    assign flush_inc = redirect_valid ? (32'(buffered) + 32'(rsp_legal)) : 32'(rsp_drop);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetched_q <= '0;
            flushed_q <= '0;
        end else begin
            if (deq_en) fetched_q <= sat_add(fetched_q, 32'd1);
            flushed_q <= sat_add(flushed_q, flush_inc);
        end
    end

    assign perf_fetched = fetched_q;
    assign perf_flushed = flushed_q;
`else
    logic unused_perf;
    assign unused_perf  = ^buffered;
    assign perf_fetched = '0;
    assign perf_flushed = '0;
`endif

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Bench for fetch_prefetch_unit: in-order variable-latency memory plus an
// epoch-based reference model of the fetch stream, directed then random phases.
module tb_fetch_prefetch_unit;

    localparam int XLEN  = 64;
    localparam int DEPTH = 4;

    logic            clk = 1'b0;
    logic            reset;
    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_addr;
    logic            imem_rsp_valid;
    logic [31:0]     imem_rsp_data;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            if_valid;
    logic            if_ready;
    logic [XLEN-1:0] if_pc;
    logic [31:0]     if_instr;
    logic [31:0]     perf_fetched;
    logic [31:0]     perf_flushed;

    always #5 clk = ~clk;

    fetch_prefetch_unit #(
        .XLEN     (XLEN),
        .DEPTH    (DEPTH),
        .RESET_PC (64'h0)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_pc          (if_pc),
        .if_instr       (if_instr),
        .perf_fetched   (perf_fetched),
        .perf_flushed   (perf_flushed)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return a[31:0] ^ a[63:32] ^ 32'hC0DE_0013;
    endfunction

    typedef struct {
        logic [63:0] addr;
        logic [63:0] pc;
        int          epoch;
        int          ready;
    } mreq_t;

    mreq_t       mem_q[$];
    logic [63:0] ret_q[$];
    logic [63:0] hs_log[$];
    logic [63:0] deq_log[$];
    logic [63:0] exp_req_pc;
    int          epoch;
    int          occ;
    int          cyc = 0;
    int          last_ready;
    bit          started;
    longint      fetched;
    longint      flushed;

    task automatic model_reset();
        mem_q.delete();
        ret_q.delete();
        exp_req_pc = 64'h0;
        epoch      = 0;
        occ        = 0;
        last_ready = 0;
        started    = 1'b0;
        fetched    = 0;
        flushed    = 0;
    endtask

    task automatic check_reset_outputs();
        chk("rst_req_valid", 64'(imem_req_valid), 64'h0);
        chk("rst_imem_addr", imem_addr, 64'h0);
        chk("rst_if_valid", 64'(if_valid), 64'h0);
        chk("rst_if_pc", if_pc, 64'h0);
        chk("rst_if_instr", 64'(if_instr), 64'h0);
        chk("rst_perf_fetched", 64'(perf_fetched), 64'h0);
        chk("rst_perf_flushed", 64'(perf_flushed), 64'h0);
    endtask

    task automatic step(input bit rr, input bit ir, input bit rd,
                        input logic [63:0] rpc, input int lat);
        bit    rv;
        bit    hs;
        bit    dq;
        bit    exp_rv;
        int    stale;
        int    rdy;
        mreq_t h;
        mreq_t n;
        @(negedge clk);
        cyc++;
        rv = (mem_q.size() > 0) && (mem_q[0].ready <= cyc);
        imem_req_ready = rr;
        if_ready       = ir;
        redirect_valid = rd;
        redirect_pc    = rpc;
        imem_rsp_valid = rv;
        imem_rsp_data  = rv ? mem_word(mem_q[0].addr) : $urandom;
        #1;
        stale = 0;
        foreach (mem_q[i]) if (mem_q[i].epoch != epoch) stale++;
        chk("if_valid", 64'(if_valid), 64'(ret_q.size() > 0));
        if (ret_q.size() > 0) begin
            chk("if_pc", if_pc, ret_q[0]);
            chk("if_instr", 64'(if_instr), 64'(mem_word(ret_q[0])));
        end
        dq     = (ret_q.size() > 0) && ir;
        exp_rv = started && !rd && (((occ + stale) < DEPTH) || dq);
        chk("req_valid", 64'(imem_req_valid), 64'(exp_rv));
`ifdef FETCH_PERF_EN
        chk("perf_fetched", 64'(perf_fetched), 64'(fetched));
        chk("perf_flushed", 64'(perf_flushed), 64'(flushed));
`else
        chk("perf_fetched_off", 64'(perf_fetched), 64'h0);
        chk("perf_flushed_off", 64'(perf_flushed), 64'h0);
`endif
        hs = imem_req_valid && rr;
        if (hs) begin
            chk("imem_addr", imem_addr, exp_req_pc);
            hs_log.push_back(imem_addr);
        end
        if (if_valid && ir && !rd) deq_log.push_back(if_pc);
        if (rv) begin
            h = mem_q.pop_front();
            if (!rd) begin
                if (h.epoch == epoch) ret_q.push_back(h.pc);
                else flushed++;
            end
        end
        if (rd) begin
            flushed += ret_q.size() + int'(rv);
            ret_q.delete();
            occ = 0;
            epoch++;
            exp_req_pc = {rpc[63:2], 2'b00};
        end else if (dq) begin
            void'(ret_q.pop_front());
            occ--;
            fetched++;
        end
        if (hs) begin
            rdy = (cyc + lat > last_ready) ? cyc + lat : last_ready;
            last_ready = rdy;
            n.addr  = imem_addr;
            n.pc    = exp_req_pc;
            n.epoch = rd ? epoch - 1 : epoch;
            n.ready = rdy;
            mem_q.push_back(n);
            if (!rd) begin
                exp_req_pc = exp_req_pc + 64'd4;
                occ++;
            end
        end
        started = 1'b1;
    endtask

    function automatic logic [63:0] first_of(input logic [63:0] q[$]);
        return (q.size() > 0) ? q[0] : 64'hDEAD_DEAD_DEAD_DEAD;
    endfunction

    initial begin
        reset          = 1'b1;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        redirect_valid = 1'b0;
        redirect_pc    = 64'h0;
        if_ready       = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        #1 check_reset_outputs();
        @(negedge clk);
        reset   = 1'b0;
        started = 1'b1;
        #1 chk("req_valid_before_first_edge", 64'(imem_req_valid), 64'h0);

        // Streaming with a 1-cycle memory: first delivery on the third cycle.
        deq_log.delete();
        hs_log.delete();
        for (int i = 0; i < 12; i++) step(1'b1, 1'b1, 1'b0, 64'h0, 1);
        chk("stream_deq_count", 64'(deq_log.size()), 64'd10);
        chk("stream_first_pc", first_of(deq_log), 64'h0);
        chk("stream_hs_count", 64'(hs_log.size()), 64'd12);

        // Decode stalled: buffer fills, one dequeue frees exactly one request.
        step(1'b1, 1'b0, 1'b1, 64'h0, 1);
        hs_log.delete();
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b0, 64'h0, 1);
        chk("full_hs_count", 64'(hs_log.size()), 64'd4);
        hs_log.delete();
        step(1'b1, 1'b1, 1'b0, 64'h0, 1);
        chk("refill_hs_count", 64'(hs_log.size()), 64'd1);
        chk("refill_addr", first_of(hs_log), 64'h10);

        // Three slow requests outstanding, then redirect to an unaligned target.
        step(1'b0, 1'b0, 1'b1, 64'h0, 1);
        hs_log.delete();
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 64'h0, 8);
        chk("slow_hs_count", 64'(hs_log.size()), 64'd3);
        step(1'b1, 1'b1, 1'b1, 64'h103, 1);
        hs_log.delete();
        deq_log.delete();
        for (int i = 0; i < 20; i++) step(1'b1, 1'b1, 1'b0, 64'h0, 1);
        chk("redir_first_addr", first_of(hs_log), 64'h100);
        chk("redir_first_if_pc", first_of(deq_log), 64'h100);

        // Redirect in the same cycle a response arrives.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 64'h0, 1);
        step(1'b1, 1'b1, 1'b1, 64'h2000, 1);
        deq_log.delete();
        for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b0, 64'h0, 1);
        chk("rsp_redir_first_if_pc", first_of(deq_log), 64'h2000);

        // PC wrap at the top of the address space.
        step(1'b1, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 1);
        hs_log.delete();
        for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b0, 64'h0, 1);
        chk("wrap_addr0", first_of(hs_log), 64'hFFFF_FFFF_FFFF_FFFC);
        chk("wrap_addr1", (hs_log.size() > 1) ? hs_log[1] : 64'hDEAD, 64'h0);

        // Asynchronous reset in the middle of traffic.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 64'h0, 2);
        @(negedge clk);
        #2 reset = 1'b1;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        redirect_valid = 1'b0;
        if_ready       = 1'b0;
        #1 check_reset_outputs();
        model_reset();
        @(negedge clk);
        reset   = 1'b0;
        started = 1'b1;
        #1 chk("req_valid_after_midrst", 64'(imem_req_valid), 64'h0);
        deq_log.delete();
        for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b0, 64'h0, 1);
        chk("midrst_first_pc", first_of(deq_log), 64'h0);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            step(($urandom % 10) < 7, ($urandom % 10) < 6, ($urandom % 40) == 0,
                 {$urandom, $urandom}, int'($urandom_range(1, 4)));
        end
        for (int i = 0; i < 40; i++) step(1'b0, 1'b1, 1'b0, 64'h0, 1);
        chk("drained_if_valid", 64'(if_valid), 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
